// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Arbitrates the icache refill port and the dcache refill/writeback port
//   onto single-beat AXI4 master transactions (AR/R or AW/W/B). The dcache
//   always wins, and a granted transaction is never preempted. Only one
//   transaction is outstanding at a time. The winner gets its read data and a
//   one-cycle ready pulse in DONE.
//
//   Ports
//     clock, reset             system clock; asynchronous active-high reset
//     icache_*                 icache read request; ready pulse and read beat back
//     dcache_*                 dcache read/write request; ready pulse and read beat back
//     axi_aw/w/b/ar/r_*        AXI4 master channels, len 0, INCR
//     bus_err                  sticky error flag
//
//   Optional feature (macro BRIDGE_RESP_CHECK_EN)
//     A non-OKAY r_resp/b_resp, or an r_id/b_id that differs from the issued
//     ID, sets bus_err until reset. When the macro is undefined, bus_err is
//     tied to 0 and the response/ID inputs are ignored.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | arbitrate; latch owner and request fields
//   AR    | read address presented
//   R     | waiting for the read beat
//   AW_W  | write address and data presented, handshaken independently
//   B     | waiting for the write response
//   DONE  | owner's ready pulse
module cache_axi_bridge #(
  parameter int AXI_ID_W = 4,
  parameter int IF_ID    = 0,
  parameter int MEM_ID   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                icache_valid,
  input  logic [31:0]         icache_addr,
  output logic                icache_ready,
  output logic [63:0]         icache_data_read,
  input  logic                dcache_valid,
  input  logic                dcache_req,
  input  logic [31:0]         dcache_addr,
  input  logic [2:0]          dcache_size,
  input  logic [63:0]         dcache_data_write,
  output logic                dcache_ready,
  output logic [63:0]         dcache_data_read,
  output logic                axi_aw_valid,
  input  logic                axi_aw_ready,
  output logic [31:0]         axi_aw_addr,
  output logic [AXI_ID_W-1:0] axi_aw_id,
  output logic [2:0]          axi_aw_size,
  output logic [7:0]          axi_aw_len,
  output logic [1:0]          axi_aw_burst,
  output logic                axi_w_valid,
  input  logic                axi_w_ready,
  output logic [63:0]         axi_w_data,
  output logic [7:0]          axi_w_strb,
  output logic                axi_w_last,
  input  logic                axi_b_valid,
  output logic                axi_b_ready,
  input  logic [1:0]          axi_b_resp,
  input  logic [AXI_ID_W-1:0] axi_b_id,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  output logic [31:0]         axi_ar_addr,
  output logic [AXI_ID_W-1:0] axi_ar_id,
  output logic [2:0]          axi_ar_size,
  output logic [7:0]          axi_ar_len,
  output logic [1:0]          axi_ar_burst,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  input  logic [63:0]         axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic                axi_r_last,
  input  logic [AXI_ID_W-1:0] axi_r_id,
  output logic                bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = dcache owns the transaction
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [63:0]   icache_data_q, icache_data_d;
  logic [63:0]   dcache_data_q, dcache_data_d;
  logic          bus_err_q, bus_err_d;
  logic [AXI_ID_W-1:0] axi_id;
  logic [15:0]   byte_mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      addr_q        <= '0;
      size_q        <= '0;
      wdata_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      icache_data_q <= '0;
      dcache_data_q <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      wdata_q       <= wdata_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      icache_data_q <= icache_data_d;
      dcache_data_q <= dcache_data_d;
      bus_err_q     <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    size_d        = size_q;
    wdata_d       = wdata_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    icache_data_d = icache_data_q;
    dcache_data_d = dcache_data_q;
    bus_err_d     = bus_err_q;
    axi_ar_valid  = 1'b0;
    axi_r_ready   = 1'b0;
    axi_aw_valid  = 1'b0;
    axi_w_valid   = 1'b0;
    axi_b_ready   = 1'b0;
    icache_ready  = 1'b0;
    dcache_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dcache_valid) begin
          owner_d   = 1'b1;
          addr_d    = dcache_addr;
          // sizes above 8 bytes do not fit the 64-bit beat; clamp to 8B
          size_d    = dcache_size[2] ? 3'd3 : dcache_size;
          wdata_d   = dcache_data_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = dcache_req ? S_AW_W : S_AR;
        end else if (icache_valid) begin
          owner_d = 1'b0;
          addr_d  = {icache_addr[31:3], 3'b000};
          size_d  = 3'd3;
          state_d = S_AR;
        end
      end
      S_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_d = S_R;
      end
      S_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          if (owner_q) dcache_data_d = axi_r_data;
          else         icache_data_d = axi_r_data;
`ifdef BRIDGE_RESP_CHECK_EN
          if (axi_r_resp != 2'b00 || axi_r_id != axi_id) bus_err_d = 1'b1;
`endif
          state_d = S_DONE;
        end
      end
      S_AW_W: begin
        axi_aw_valid = ~aw_done_q;
        axi_w_valid  = ~w_done_q;
        if (axi_aw_ready) aw_done_d = 1'b1;
        if (axi_w_ready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
`ifdef BRIDGE_RESP_CHECK_EN
          if (axi_b_resp != 2'b00 || axi_b_id != axi_id) bus_err_d = 1'b1;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        icache_ready = ~owner_q;
        dcache_ready = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign axi_id = owner_q ? AXI_ID_W'(MEM_ID) : AXI_ID_W'(IF_ID);

  // (1 << size) bytes of ones, then shifted into the addressed lanes
  assign byte_mask = (16'd1 << (4'd1 << size_q[1:0])) - 16'd1;

  assign axi_ar_addr  = addr_q;
  assign axi_ar_id    = axi_id;
  assign axi_ar_size  = size_q;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_burst = 2'b01;
  assign axi_aw_addr  = addr_q;
  assign axi_aw_id    = axi_id;
  assign axi_aw_size  = size_q;
  assign axi_aw_len   = 8'd0;
  assign axi_aw_burst = 2'b01;
  assign axi_w_data   = wdata_q;
  assign axi_w_strb   = byte_mask[7:0] << addr_q[2:0];
  assign axi_w_last   = 1'b1;

  assign icache_data_read = icache_data_q;
  assign dcache_data_read = dcache_data_q;
  assign bus_err          = bus_err_q;

`ifdef BRIDGE_RESP_CHECK_EN
  logic unused_in;
  assign unused_in = ^{icache_addr[2:0], axi_r_last};
`else
  logic unused_in;
  assign unused_in = ^{icache_addr[2:0], axi_r_last, axi_r_resp, axi_r_id,
                       axi_b_resp, axi_b_id};
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;
  localparam int IDW = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           icache_valid, icache_ready;
  logic [31:0]    icache_addr;
  logic [63:0]    icache_data_read;
  logic           dcache_valid, dcache_req, dcache_ready;
  logic [31:0]    dcache_addr;
  logic [2:0]     dcache_size;
  logic [63:0]    dcache_data_write, dcache_data_read;
  logic           axi_aw_valid, axi_aw_ready;
  logic [31:0]    axi_aw_addr;
  logic [IDW-1:0] axi_aw_id;
  logic [2:0]     axi_aw_size;
  logic [7:0]     axi_aw_len;
  logic [1:0]     axi_aw_burst;
  logic           axi_w_valid, axi_w_ready, axi_w_last;
  logic [63:0]    axi_w_data;
  logic [7:0]     axi_w_strb;
  logic           axi_b_valid, axi_b_ready;
  logic [1:0]     axi_b_resp;
  logic [IDW-1:0] axi_b_id;
  logic           axi_ar_valid, axi_ar_ready;
  logic [31:0]    axi_ar_addr;
  logic [IDW-1:0] axi_ar_id;
  logic [2:0]     axi_ar_size;
  logic [7:0]     axi_ar_len;
  logic [1:0]     axi_ar_burst;
  logic           axi_r_valid, axi_r_ready, axi_r_last;
  logic [63:0]    axi_r_data;
  logic [1:0]     axi_r_resp;
  logic [IDW-1:0] axi_r_id;
  logic           bus_err;

  cache_axi_bridge #(.AXI_ID_W(IDW), .IF_ID(0), .MEM_ID(1)) dut (
    .clock(clock), .reset(reset),
    .icache_valid(icache_valid), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data_read(icache_data_read),
    .dcache_valid(dcache_valid), .dcache_req(dcache_req),
    .dcache_addr(dcache_addr), .dcache_size(dcache_size),
    .dcache_data_write(dcache_data_write), .dcache_ready(dcache_ready),
    .dcache_data_read(dcache_data_read),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_aw_addr(axi_aw_addr), .axi_aw_id(axi_aw_id), .axi_aw_size(axi_aw_size),
    .axi_aw_len(axi_aw_len), .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_b_id(axi_b_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_id(axi_ar_id), .axi_ar_size(axi_ar_size),
    .axi_ar_len(axi_ar_len), .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [63:0] req_q[$];   // expected AXI request fields, in grant order
  logic [63:0] rd_q[$];    // expected read data for the next completion

`ifdef BRIDGE_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [63:0] obs, output logic [63:0] e);
    if (req_q.size() == 0) e = 64'hDEAD_DEAD_DEAD_DEAD;
    else                   e = req_q.pop_front();
    check(tag, obs, e);
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] clamp(input logic [2:0] s);
    return (s > 3'd3) ? 3'd3 : s;
  endfunction

  task automatic issue_icache(input logic [31:0] a);
    icache_addr  = a;
    icache_valid = 1'b1;
    req_q.push_back({32'd0, a[31:3], 3'b000});
    req_q.push_back(64'd3);
    req_q.push_back(64'd0);
  endtask

  task automatic issue_dread(input logic [31:0] a, input logic [2:0] s);
    dcache_addr  = a;
    dcache_size  = s;
    dcache_req   = 1'b0;
    dcache_valid = 1'b1;
    req_q.push_back({32'd0, a});
    req_q.push_back({61'd0, clamp(s)});
    req_q.push_back(64'd1);
  endtask

  task automatic issue_dwrite(input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
    int nbytes;
    int mask;
    nbytes = 1 << clamp(s);
    mask   = ((1 << nbytes) - 1) << a[2:0];
    dcache_addr       = a;
    dcache_size       = s;
    dcache_data_write = d;
    dcache_req        = 1'b1;
    dcache_valid      = 1'b1;
    req_q.push_back({32'd0, a});
    req_q.push_back({61'd0, clamp(s)});
    req_q.push_back(64'd1);
    req_q.push_back(d);
    req_q.push_back({56'd0, mask[7:0]});
  endtask

  task automatic do_read(input int ar_dly, input int r_dly, input logic [63:0] rdata,
                         input logic [1:0] rresp);
    logic [63:0] e;
    for (int i = 0; i < 40 && axi_ar_valid !== 1'b1; i++) cyc;
    check("ar_valid_seen", axi_ar_valid, 1);
    pop_check("ar_addr", axi_ar_addr, e);
    pop_check("ar_size", axi_ar_size, e);
    pop_check("ar_id", axi_ar_id, e);
    check("ar_len", axi_ar_len, 0);
    check("ar_burst", axi_ar_burst, 1);
    repeat (ar_dly) begin
      cyc;
      check("ar_valid_hold", axi_ar_valid, 1);
    end
    axi_ar_ready = 1'b1;
    cyc;
    axi_ar_ready = 1'b0;
    check("ar_valid_drop", axi_ar_valid, 0);
    check("r_ready", axi_r_ready, 1);
    repeat (r_dly) cyc;
    axi_r_valid = 1'b1;
    axi_r_data  = rdata;
    axi_r_resp  = rresp;
    axi_r_last  = 1'b1;
    axi_r_id    = e[IDW-1:0];
    rd_q.push_back(rdata);
    cyc;
    axi_r_valid = 1'b0;
  endtask

  task automatic do_write(input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp);
    logic [63:0] e;
    logic [IDW-1:0] id;
    int n;
    for (int i = 0; i < 40 && axi_aw_valid !== 1'b1; i++) cyc;
    check("aw_valid_seen", axi_aw_valid, 1);
    pop_check("aw_addr", axi_aw_addr, e);
    pop_check("aw_size", axi_aw_size, e);
    pop_check("aw_id", axi_aw_id, e);
    id = e[IDW-1:0];
    pop_check("w_data", axi_w_data, e);
    pop_check("w_strb", axi_w_strb, e);
    check("w_last", axi_w_last, 1);
    check("aw_len", axi_aw_len, 0);
    n = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int k = 0; k <= n; k++) begin
      check("aw_valid_phase", axi_aw_valid, (k <= aw_dly) ? 64'd1 : 64'd0);
      check("w_valid_phase", axi_w_valid, (k <= w_dly) ? 64'd1 : 64'd0);
      axi_aw_ready = (k == aw_dly);
      axi_w_ready  = (k == w_dly);
      cyc;
    end
    axi_aw_ready = 1'b0;
    axi_w_ready  = 1'b0;
    check("b_ready", axi_b_ready, 1);
    check("aw_no_dup", axi_aw_valid, 0);
    check("w_no_dup", axi_w_valid, 0);
    repeat (b_dly) cyc;
    axi_b_valid = 1'b1;
    axi_b_resp  = bresp;
    axi_b_id    = id;
    cyc;
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
  endtask

  task automatic expect_done(input logic dport, input logic is_read);
    logic [63:0] e;
    check("icache_ready_pulse", icache_ready, {63'd0, ~dport});
    check("dcache_ready_pulse", dcache_ready, {63'd0, dport});
    if (is_read) begin
      e = (rd_q.size() == 0) ? 64'hDEAD_DEAD_DEAD_DEAD : rd_q.pop_front();
      if (dport) check("dcache_data_read", dcache_data_read, e);
      else       check("icache_data_read", icache_data_read, e);
    end
    if (dport) dcache_valid = 1'b0;
    else       icache_valid = 1'b0;
    cyc;
    check("icache_ready_single", icache_ready, 0);
    check("dcache_ready_single", dcache_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    icache_valid = 0; icache_addr = 0;
    dcache_valid = 0; dcache_req = 0; dcache_addr = 0; dcache_size = 0;
    dcache_data_write = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0;
    axi_r_last = 0; axi_r_id = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ar_valid", axi_ar_valid, 0);
    check("rst_aw_valid", axi_aw_valid, 0);
    check("rst_w_valid", axi_w_valid, 0);
    check("rst_r_ready", axi_r_ready, 0);
    check("rst_b_ready", axi_b_ready, 0);
    check("rst_icache_ready", icache_ready, 0);
    check("rst_dcache_ready", dcache_ready, 0);
    check("rst_ar_addr", axi_ar_addr, 0);
    check("rst_icache_data", icache_data_read, 0);
    check("rst_dcache_data", dcache_data_read, 0);
    check("rst_bus_err", bus_err, 0);
    reset = 1'b0;
    cyc;

    // icache read, unaligned fetch address, slow slave
    issue_icache(32'h8000_0004);
    do_read(2, 3, 64'h1122_3344_5566_7788, 2'b00);
    expect_done(1'b0, 1'b1);
    cyc;

    // simultaneous requests: dcache first, icache after one idle cycle
    issue_dread(32'h1000_0010, 3'd2);
    issue_icache(32'h2000_002C);
    do_read(0, 0, 64'hA5A5_5A5A_0000_FFFF, 2'b00);
    check("icache_no_ready_during_d", icache_ready, 0);
    check("icache_data_hold", icache_data_read, 64'h1122_3344_5566_7788);
    expect_done(1'b1, 1'b1);
    check("gap_idle", axi_ar_valid, 0);
    cyc;
    check("icache_ar_next", axi_ar_valid, 1);
    do_read(1, 1, 64'h0F0E_0D0C_0B0A_0908, 2'b00);
    expect_done(1'b0, 1'b1);
    cyc;

    // halfword write to the top lanes; aw accepted 3 cycles before w
    issue_dwrite(32'h8000_0106, 3'd1, 64'hBEEF_0000_0000_0000);
    cyc;
    dcache_addr = 32'hDEAD_BEEF; dcache_size = 3'd0;
    dcache_data_write = '1; dcache_req = 1'b0;
    do_write(0, 3, 2, 2'b00);
    expect_done(1'b1, 1'b0);
    check("dcache_data_hold", dcache_data_read, 64'hA5A5_5A5A_0000_FFFF);
    cyc;

    // out-of-range size, both handshakes on the first cycle
    issue_dwrite(32'h4000_0008, 3'd7, 64'h0123_4567_89AB_CDEF);
    do_write(0, 0, 0, 2'b00);
    expect_done(1'b1, 1'b0);
    cyc;

    // reset while waiting for read data
    issue_icache(32'h3000_0010);
    begin
      logic [63:0] e;
      for (int i = 0; i < 40 && axi_ar_valid !== 1'b1; i++) cyc;
      check("rstR_ar_seen", axi_ar_valid, 1);
      pop_check("rstR_ar_addr", axi_ar_addr, e);
      pop_check("rstR_ar_size", axi_ar_size, e);
      pop_check("rstR_ar_id", axi_ar_id, e);
    end
    axi_ar_ready = 1'b1;
    cyc;
    axi_ar_ready = 1'b0;
    check("rstR_in_r", axi_r_ready, 1);
    #2;
    reset = 1'b1;
    icache_valid = 1'b0;
    #1;
    check("rstR_r_ready", axi_r_ready, 0);
    check("rstR_ar_valid", axi_ar_valid, 0);
    check("rstR_icache_ready", icache_ready, 0);
    check("rstR_icache_data", icache_data_read, 0);
    check("rstR_dcache_data", dcache_data_read, 0);
    repeat (3) begin
      cyc;
      check("rstR_no_pulse_i", icache_ready, 0);
      check("rstR_no_pulse_d", dcache_ready, 0);
    end
    reset = 1'b0;
    cyc;
    issue_dread(32'h5000_0020, 3'd3);
    do_read(1, 0, 64'hCAFE_F00D_CAFE_F00D, 2'b00);
    expect_done(1'b1, 1'b1);
    cyc;

    // SLVERR on write response, then an OKAY read
    issue_dwrite(32'h6000_0000, 3'd2, 64'h0000_0000_1234_5678);
    do_write(1, 0, 1, 2'b10);
    expect_done(1'b1, 1'b0);
    check("bus_err_after_slverr", bus_err, {63'd0, EXP_ERR});
    cyc;
    issue_icache(32'h7000_0040);
    do_read(0, 0, 64'h5555_AAAA_5555_AAAA, 2'b00);
    expect_done(1'b0, 1'b1);
    check("bus_err_sticky", bus_err, {63'd0, EXP_ERR});

    check("scoreboard_empty", req_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Downstream of the CPU core's two cache miss ports. Consumes the icache refill request and the dcache refill/writeback request.
- Arbitrates between the two ports and converts the winner into single-beat AXI4 master transactions (AR/R or AW/W/B).
- Returns data and a one-cycle ready pulse to the requester that won.
- At most one transaction is outstanding at any time.

Parameters:
- AXI_ID_W, 4, width of the AXI ID fields.
- IF_ID, 0, ARID used for icache reads.
- MEM_ID, 1, ARID/AWID used for dcache accesses.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- icache_valid  in  1  icache read request; held high until icache_ready
- icache_addr  in  32  icache fetch address
- icache_ready  out  1  one-cycle pulse; icache_data_read valid this cycle
- icache_data_read  out  64  read beat returned to icache
- dcache_valid  in  1  dcache request; held high until dcache_ready
- dcache_req  in  1  1 = write, 0 = read
- dcache_addr  in  32  byte address
- dcache_size  in  3  AXI size encoding: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- dcache_data_write  in  64  write data, already placed in its byte lanes
- dcache_ready  out  1  one-cycle pulse; read data valid / write acknowledged
- dcache_data_read  out  64  read beat returned to dcache
- axi_aw_valid/ready, axi_aw_addr[31:0], axi_aw_id[AXI_ID_W], axi_aw_size[2:0], axi_aw_len[7:0], axi_aw_burst[1:0]  AW channel
- axi_w_valid/ready, axi_w_data[63:0], axi_w_strb[7:0], axi_w_last  W channel
- axi_b_valid/ready, axi_b_resp[1:0], axi_b_id  B channel
- axi_ar_valid/ready, axi_ar_addr[31:0], axi_ar_id, axi_ar_size[2:0], axi_ar_len[7:0], axi_ar_burst[1:0]  AR channel
- axi_r_valid/ready, axi_r_data[63:0], axi_r_resp[1:0], axi_r_last, axi_r_id  R channel
- bus_err  out  1  sticky AXI error flag (see Optional Feature)

Behaviour:
- Reset (async, active-high): state goes to IDLE. All valid/ready outputs are 0. Data/addr outputs are 0. bus_err is 0.
- FSM states: IDLE, AR, R, AW_W, B, DONE. Grant owner is latched on leaving IDLE.
- IDLE arbitration is fixed priority, dcache first:
  - dcache_valid & dcache_req -> AW_W.
  - dcache_valid & ~dcache_req -> AR.
  - else icache_valid -> AR.
  - A granted transaction is never preempted.
- Request fields are captured into registers at grant. Requester inputs may change after grant without effect.
- AR state:
  - axi_ar_valid = 1.
  - icache: addr = {icache_addr[31:3], 3'b000}, size = 3, id = IF_ID.
  - dcache: addr = dcache_addr, size = dcache_size, id = MEM_ID.
  - len = 0, burst = 1 (INCR).
  - On ar_valid & ar_ready, go to R.
- R state:
  - axi_r_ready = 1.
  - On r_valid, capture r_data into the owner's data_read register and go to DONE.
  - r_last is ignored (len = 0).
- AW_W state:
  - aw_valid and w_valid both rise on entry. Each drops independently after its own handshake.
  - Go to B once both handshakes are complete; both may complete in the same cycle.
  - w_last = 1.
  - w_strb = mask of (1 << size) bytes, shifted left by addr[2:0]. Example: size 1, addr[2:0] = 6 -> 8'hC0.
- B state: b_ready = 1. On b_valid, go to DONE.
- DONE state:
  - The owner's ready is 1 for exactly this cycle; the other port's ready stays 0.
  - Next state is IDLE.
  - Requester drops valid at the same edge. IDLE re-arbitrates on the next cycle, so the minimum request-to-request gap is 1 idle cycle.
- data_read registers hold their value until the next read for the same port.
- Out-of-range sizes (dcache_size 4..7) are treated as 3.
- Reset asserted mid-transaction aborts immediately. Valids drop with no completion pulse. The AXI slave is assumed to be reset by the same signal.

Optional Feature:
- Macro: BRIDGE_RESP_CHECK_EN.
- When defined:
  - r_resp or b_resp != 0 at its handshake sets bus_err, which stays high until reset.
  - The transaction still completes normally and ready still pulses.
  - A mismatch of r_id/b_id against the latched ID also sets bus_err.
- When undefined: bus_err is tied to 0 and resp/id inputs are unused.

Test Plan:
- icache_valid, addr 0x8000_0004; slave ar_ready after 2 cycles, r_data 0x1122334455667788 after 3 -> ar_addr 0x8000_0000, size 3, id 0; icache_ready single pulse; data_read = 0x1122334455667788.
- icache and dcache read asserted together in IDLE -> dcache AR (id 1) goes first; icache AR issues on the cycle after DONE + 1 idle cycle.
- dcache write, addr 0x8000_0106, size 1, data 0xBEEF000000000000; aw_ready 3 cycles before w_ready -> aw_valid drops first; w_strb 8'hC0; dcache_ready pulses 1 cycle after b_valid.
- Write with aw_ready and w_ready both high on the first cycle -> both valids drop together; next state B; no duplicate AW.
- Reset asserted while in R -> all outputs 0 the same cycle; no ready pulse; a fresh request after reset completes normally.
- With BRIDGE_RESP_CHECK_EN: b_resp = 2'b10 -> bus_err = 1 and stays 1 across a later OKAY transaction. Without the macro -> bus_err stays 0.
